// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register for the RV32I core: captures memory-stage results,
// aligns/extends load data, counts retired instructions. Optional: MEM_WB_LOAD_ALIGN_EN.
module mem_wb_stage #(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned REG_ADDR_W = 5,
   parameter int unsigned CNT_W      = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  stall,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [XLEN-1:0]       in_alu_result,
   input  logic [XLEN-1:0]       in_mem_rdata,
   input  logic                  in_mem_to_reg,
   input  logic                  in_reg_write,
   input  logic [REG_ADDR_W-1:0] in_rd,
   input  logic [2:0]            in_funct3,
   output logic                  out_valid,
   output logic [XLEN-1:0]       alu_result,
   output logic [XLEN-1:0]       mem_data,
   output logic                  mem_to_reg,
   output logic                  reg_write,
   output logic [REG_ADDR_W-1:0] rd,
   output logic                  load_misalign,
   output logic [CNT_W-1:0]      retire_count
);

   logic [XLEN-1:0]       load_data_c;
   logic                  misalign_c;

   logic                  valid_nxt;
   logic [XLEN-1:0]       alu_nxt;
   logic [XLEN-1:0]       mem_nxt;
   logic                  m2r_nxt;
   logic                  rw_nxt;
   logic [REG_ADDR_W-1:0] rd_nxt;
   logic                  mis_nxt;
   logic [CNT_W-1:0]      cnt_nxt;

   assign in_ready = ~stall;

`ifdef MEM_WB_LOAD_ALIGN_EN
   logic [XLEN-1:0] byte_sh;
   logic [XLEN-1:0] half_sh;

   // Shift the addressed byte/half into the low lanes, then extend by funct3
   always_comb begin
      byte_sh     = in_mem_rdata >> {in_alu_result[1:0], 3'b000};
      half_sh     = in_mem_rdata >> {in_alu_result[1], 4'b0000};
      load_data_c = in_mem_rdata;
      misalign_c  = 1'b0;
      case (in_funct3)
         3'b000: load_data_c = {{(XLEN-8){byte_sh[7]}}, byte_sh[7:0]};
         3'b100: load_data_c = {{(XLEN-8){1'b0}}, byte_sh[7:0]};
         3'b001: begin
            if (in_alu_result[0]) misalign_c = 1'b1;
            else load_data_c = {{(XLEN-16){half_sh[15]}}, half_sh[15:0]};
         end
         3'b101: begin
            if (in_alu_result[0]) misalign_c = 1'b1;
            else load_data_c = {{(XLEN-16){1'b0}}, half_sh[15:0]};
         end
         default: misalign_c = (in_alu_result[1:0] != 2'b00);
      endcase
   end
`else
   logic unused_funct3;

   assign unused_funct3 = ^in_funct3;
   assign load_data_c   = in_mem_rdata;
   assign misalign_c    = 1'b0;
`endif

   // Next-state selection: flush > stall > load
   always_comb begin
      valid_nxt = out_valid;
      alu_nxt   = alu_result;
      mem_nxt   = mem_data;
      m2r_nxt   = mem_to_reg;
      rw_nxt    = reg_write;
      rd_nxt    = rd;
      mis_nxt   = load_misalign;
      cnt_nxt   = retire_count;

      if (out_valid && !stall) cnt_nxt = retire_count + CNT_W'(1);

      if (flush) begin
         valid_nxt = 1'b0;
         rw_nxt    = 1'b0;
         m2r_nxt   = 1'b0;
         mis_nxt   = 1'b0;
      end else if (!stall) begin
         valid_nxt = in_valid;
         if (in_valid) begin
            alu_nxt = in_alu_result;
            mem_nxt = in_mem_to_reg ? load_data_c : '0;
            m2r_nxt = in_mem_to_reg;
            rw_nxt  = in_reg_write && (in_rd != '0);
            rd_nxt  = in_rd;
            mis_nxt = in_mem_to_reg && misalign_c;
         end else begin
            rw_nxt  = 1'b0;
            m2r_nxt = 1'b0;
            mis_nxt = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid     <= 1'b0;
         alu_result    <= '0;
         mem_data      <= '0;
         mem_to_reg    <= 1'b0;
         reg_write     <= 1'b0;
         rd            <= '0;
         load_misalign <= 1'b0;
         retire_count  <= '0;
      end else begin
         out_valid     <= valid_nxt;
         alu_result    <= alu_nxt;
         mem_data      <= mem_nxt;
         mem_to_reg    <= m2r_nxt;
         reg_write     <= rw_nxt;
         rd            <= rd_nxt;
         load_misalign <= mis_nxt;
         retire_count  <= cnt_nxt;
      end
   end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed cases plus randomized traffic
// against a behavioural reference model. Honors MEM_WB_LOAD_ALIGN_EN.
module tb_mem_wb_stage;

   localparam int unsigned XLEN       = 32;
   localparam int unsigned REG_ADDR_W = 5;
   localparam int unsigned CNT_W      = 4;

   logic                  clk = 1'b0;
   logic                  rst, stall, flush, in_valid, in_ready;
   logic [XLEN-1:0]       in_alu_result, in_mem_rdata;
   logic                  in_mem_to_reg, in_reg_write;
   logic [REG_ADDR_W-1:0] in_rd;
   logic [2:0]            in_funct3;
   logic                  out_valid, mem_to_reg, reg_write, load_misalign;
   logic [XLEN-1:0]       alu_result, mem_data;
   logic [REG_ADDR_W-1:0] rd;
   logic [CNT_W-1:0]      retire_count;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state
   bit          m_valid, m_m2r, m_rw, m_mis;
   logic [31:0] m_alu, m_mem;
   int          m_rd, m_cnt;

   mem_wb_stage #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_alu_result(in_alu_result), .in_mem_rdata(in_mem_rdata),
      .in_mem_to_reg(in_mem_to_reg), .in_reg_write(in_reg_write),
      .in_rd(in_rd), .in_funct3(in_funct3),
      .out_valid(out_valid), .alu_result(alu_result), .mem_data(mem_data),
      .mem_to_reg(mem_to_reg), .reg_write(reg_write), .rd(rd),
      .load_misalign(load_misalign), .retire_count(retire_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // RV32I load semantics computed from byte/half selection by address
   function automatic logic [31:0] ref_load(input logic [31:0] rdata, input logic [31:0] addr,
                                            input logic [2:0] f3, output bit mis);
      logic [7:0]  b;
      logic [15:0] h;
      mis = 0;
`ifdef MEM_WB_LOAD_ALIGN_EN
      b = 8'(rdata >> (8 * int'(addr[1:0])));
      h = 16'(rdata >> (16 * int'(addr[1])));
      case (f3)
         3'd0: return 32'($signed(b));
         3'd4: return 32'(b);
         3'd1, 3'd5: begin
            if (addr[0]) begin mis = 1; return rdata; end
            return (f3 == 3'd1) ? 32'($signed(h)) : 32'(h);
         end
         default: begin
            mis = (addr % 4) != 0;
            return rdata;
         end
      endcase
`else
      b = 8'(f3);
      h = 16'(b);
      return rdata;
`endif
   endfunction

   task automatic model_update();
      bit mis;
      logic [31:0] ld;
      if (rst) begin
         m_valid = 0; m_m2r = 0; m_rw = 0; m_mis = 0;
         m_alu = 0; m_mem = 0; m_rd = 0; m_cnt = 0;
         return;
      end
      if (m_valid && !stall) m_cnt = (m_cnt + 1) % (1 << CNT_W);
      if (flush) m_valid = 0;
      else if (!stall) begin
         m_valid = in_valid;
         if (in_valid) begin
            ld    = ref_load(in_mem_rdata, in_alu_result, in_funct3, mis);
            m_alu = in_alu_result;
            m_m2r = in_mem_to_reg;
            m_mem = in_mem_to_reg ? ld : 32'h0;
            m_mis = in_mem_to_reg && mis;
            m_rw  = in_reg_write;
            m_rd  = int'(in_rd);
         end
      end
   endtask

   task automatic compare_all();
      check("out_valid", 64'(out_valid), 64'(m_valid));
      check("reg_write", 64'(reg_write), 64'(m_valid && m_rw && m_rd != 0));
      check("mem_to_reg", 64'(mem_to_reg), 64'(m_valid && m_m2r));
      check("load_misalign", 64'(load_misalign), 64'(m_valid && m_mis));
      check("retire_count", 64'(retire_count), 64'(m_cnt));
      if (m_valid) begin
         check("alu_result", 64'(alu_result), 64'(m_alu));
         check("mem_data", 64'(mem_data), 64'(m_mem));
         check("rd", 64'(rd), 64'(m_rd));
      end
   endtask

   // Inputs already set at the negedge; check in_ready, clock once, compare
   task automatic cycle();
      #1 check("in_ready", 64'(in_ready), 64'(!stall));
      @(posedge clk);
      model_update();
      @(negedge clk);
      compare_all();
   endtask

   task automatic set_op(input bit v, input logic [31:0] alu, input logic [31:0] rdata,
                         input bit m2r, input bit rw, input int rdi, input logic [2:0] f3);
      in_valid = v; in_alu_result = alu; in_mem_rdata = rdata;
      in_mem_to_reg = m2r; in_reg_write = rw; in_rd = REG_ADDR_W'(rdi); in_funct3 = f3;
   endtask

   initial begin
      rst = 1; stall = 0; flush = 0;
      set_op(0, 32'h0, 32'h0, 0, 0, 0, 3'd0);
      @(negedge clk);

      // reset held two cycles, then released with no traffic
      cycle(); cycle();
      check("rst_alu", 64'(alu_result), 64'h0);
      check("rst_mem", 64'(mem_data), 64'h0);
      check("rst_rd", 64'(rd), 64'h0);
      check("rst_cnt", 64'(retire_count), 64'h0);
      rst = 0;
      cycle();
      check("idle_valid", 64'(out_valid), 64'h0);
      check("idle_alu", 64'(alu_result), 64'h0);

      // plain ALU op
      set_op(1, 32'hAAAABBBB, 32'h12345678, 0, 1, 5, 3'd2);
      cycle();
      check("alu_op_res", 64'(alu_result), 64'hAAAABBBB);
      check("alu_op_rw", 64'(reg_write), 64'h1);
      check("alu_op_mem", 64'(mem_data), 64'h0);
      check("alu_op_cnt0", 64'(retire_count), 64'h0);
      set_op(0, 32'h0, 32'h0, 0, 0, 0, 3'd0);
      cycle();
      check("alu_op_cnt1", 64'(retire_count), 64'h1);

      // sub-word loads
      set_op(1, 32'h10000003, 32'h80112233, 1, 1, 6, 3'd0);
      cycle();
`ifdef MEM_WB_LOAD_ALIGN_EN
      check("lb", 64'(mem_data), 64'hFFFFFF80);
`else
      check("lb_raw", 64'(mem_data), 64'h80112233);
`endif
      set_op(1, 32'h10000003, 32'h80112233, 1, 1, 6, 3'd4);
      cycle();
`ifdef MEM_WB_LOAD_ALIGN_EN
      check("lbu", 64'(mem_data), 64'h00000080);
`endif
      set_op(1, 32'h10000002, 32'h80011234, 1, 1, 6, 3'd1);
      cycle();
`ifdef MEM_WB_LOAD_ALIGN_EN
      check("lh", 64'(mem_data), 64'hFFFF8001);
`endif
      set_op(1, 32'h10000002, 32'hCAFEF00D, 1, 1, 6, 3'd2);
      cycle();
      check("lw_mis_data", 64'(mem_data), 64'hCAFEF00D);
`ifdef MEM_WB_LOAD_ALIGN_EN
      check("lw_mis_flag", 64'(load_misalign), 64'h1);
`else
      check("lw_mis_flag", 64'(load_misalign), 64'h0);
`endif

      // stall freezes contents while inputs change
      set_op(1, 32'h12345678, 32'h0, 0, 1, 7, 3'd0);
      cycle();
      stall = 1;
      for (int i = 0; i < 3; i++) begin
         set_op(1, $urandom, $urandom, 1'($urandom), 1, 9 + i, 3'd0);
         cycle();
         check("stall_alu", 64'(alu_result), 64'h12345678);
         check("stall_rd", 64'(rd), 64'd7);
      end
      flush = 1;
      cycle();
      check("flush_stall_valid", 64'(out_valid), 64'h0);
      check("flush_stall_rw", 64'(reg_write), 64'h0);
      stall = 0; flush = 0;

      // x0 destination never written
      set_op(1, 32'h5, 32'h0, 0, 1, 0, 3'd0);
      cycle();
      check("x0_rw", 64'(reg_write), 64'h0);

      // drive the counter to its top value then wrap
      set_op(1, 32'h1, 32'h0, 0, 1, 3, 3'd0);
      for (int i = 0; i < 40 && m_cnt != 15; i++) cycle();
      check("cnt_top", 64'(retire_count), 64'd15);
      cycle();
      check("cnt_wrap", 64'(retire_count), 64'd0);

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         rst   = ($urandom_range(99) < 2);
         stall = ($urandom_range(99) < 25);
         flush = ($urandom_range(99) < 10);
         set_op(1'($urandom_range(99) < 75), $urandom, $urandom, 1'($urandom),
                1'($urandom), (($urandom_range(9) == 0) ? 0 : int'($urandom_range(31))),
                3'($urandom_range(7)));
         cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
